mesh_port_buffer: RTL and testbench

MESH_PORT_BUFFER -- requirements
Module: mesh_port_buffer

---
 rtl/mesh_pkg.sv | 34 +++
 rtl/mesh_port_fifo.sv | 82 ++++++++
 rtl/mesh_port_buffer.sv | 49 ++++
 tb/tb_mesh_port_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared header layout, destination legality and occupancy sizing for the mesh port buffer.
package mesh_pkg;

  localparam int unsigned JUMP_W  = 8;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned COL_W   = 4;
  // Field offsets measured down from the packet MSB
  localparam int unsigned ROW_OFS = JUMP_W;
  localparam int unsigned COL_OFS = JUMP_W + ROW_W;

  localparam logic [ROW_W-1:0] BCAST_ROW = 4'hF;
  localparam logic [COL_W-1:0] BCAST_COL = 4'hF;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } dest_t;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic is_broadcast(input dest_t dest);
    return (dest.row == BCAST_ROW) && (dest.col == BCAST_COL);
  endfunction

  // Broadcast is always legal; otherwise the destination must sit inside the mesh ring
  function automatic logic is_legal(input dest_t dest, input int unsigned rows,
                                    input int unsigned cols);
    return is_broadcast(dest) ||
           ((32'(dest.row) <= rows + 1) && (32'(dest.col) <= cols + 1));
  endfunction

endpackage

// File: rtl/mesh_port_fifo.sv
// Single terminal channel: first-word fall-through FIFO with drop counting,
// legality filtering, flush and sticky underflow.
module mesh_port_fifo
  import mesh_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic [pckg_sz-1:0]                 data_in,
  input  logic                               flush,
  input  logic                               popin,
  output logic                               pndng,
  output logic [pckg_sz-1:0]                 data_out,
  output logic                               full,
  output logic [occ_width(fifo_depth)-1:0]   occ,
  output logic [15:0]                        drop_cnt,
  output logic                               underflow
);

  localparam int unsigned PW = $clog2(fifo_depth);
  localparam int unsigned CW = occ_width(fifo_depth);

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  dest_t dest;
  logic  legal;
  logic  empty;
  logic  is_full;
  logic  do_pop;
  logic  accept;
  logic  drop;

  assign dest.row = data_in[pckg_sz-1-ROW_OFS -: ROW_W];
  assign dest.col = data_in[pckg_sz-1-COL_OFS -: COL_W];
  assign legal    = is_legal(dest, ROWS, COLUMS);

  assign empty   = (count == '0);
  assign is_full = (count == CW'(fifo_depth));
  assign do_pop  = popin && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs
  assign accept  = push && legal && (!is_full || do_pop);
  assign drop    = push && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(do_pop);
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (popin && empty) underflow <= 1'b1;
    end
  end

  // Storage carries no reset; empty channels mask the head to zero
  always_ff @(posedge clk) begin
    if (accept && !flush && !reset) mem[wr_ptr] <= data_in;
  end

  assign pndng    = !empty;
  assign full     = is_full;
  assign occ      = count;
  assign data_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mesh_port_buffer.sv
// Terminal-side port buffer of a mesh router: one independent FIFO per channel.
module mesh_port_buffer
  import mesh_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned NCH        = 2*ROWS + 2*COLUMS,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NCH-1:0]                         push,
  input  logic [NCH*pckg_sz-1:0]                 data_in,
  input  logic [NCH-1:0]                         flush,
  input  logic [NCH-1:0]                         popin,
  output logic [NCH-1:0]                         pndng_i_in,
  output logic [NCH*pckg_sz-1:0]                 data_out_i_in,
  output logic [NCH-1:0]                         full,
  output logic [NCH*occ_width(fifo_depth)-1:0]   occ,
  output logic [NCH*16-1:0]                      drop_cnt,
  output logic [NCH-1:0]                         underflow
);

  localparam int unsigned OW = occ_width(fifo_depth);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mesh_port_fifo #(
      .ROWS       (ROWS),
      .COLUMS     (COLUMS),
      .pckg_sz    (pckg_sz),
      .fifo_depth (fifo_depth)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .data_in   (data_in[i*pckg_sz +: pckg_sz]),
      .flush     (flush[i]),
      .popin     (popin[i]),
      .pndng     (pndng_i_in[i]),
      .data_out  (data_out_i_in[i*pckg_sz +: pckg_sz]),
      .full      (full[i]),
      .occ       (occ[i*OW +: OW]),
      .drop_cnt  (drop_cnt[i*16 +: 16]),
      .underflow (underflow[i])
    );
  end

endmodule

// File: tb/tb_mesh_port_buffer.sv
// Directed plus randomized bench for mesh_port_buffer against a queue-based channel model.
module tb_mesh_port_buffer;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLUMS = 4;
  localparam int unsigned NCH    = 16;
  localparam int unsigned P      = 40;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned OW     = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic [NCH-1:0]     push;
  logic [NCH*P-1:0]   data_in;
  logic [NCH-1:0]     flush;
  logic [NCH-1:0]     popin;
  logic [NCH-1:0]     pndng_i_in;
  logic [NCH*P-1:0]   data_out_i_in;
  logic [NCH-1:0]     full;
  logic [NCH*OW-1:0]  occ;
  logic [NCH*16-1:0]  drop_cnt;
  logic [NCH-1:0]     underflow;

  always #5 clk = ~clk;

  mesh_port_buffer #(
    .ROWS(ROWS), .COLUMS(COLUMS), .NCH(NCH), .pckg_sz(P), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .flush(flush),
    .popin(popin), .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in),
    .full(full), .occ(occ), .drop_cnt(drop_cnt), .underflow(underflow)
  );

  int tests = 0;
  int fails = 0;

  logic [P-1:0] mq [NCH][$];
  int unsigned  mdrop [NCH];
  logic         mund [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [P-1:0] pkt(input logic [3:0] r, input logic [3:0] c,
                                       input logic [23:0] pl);
    return {8'h00, r, c, pl};
  endfunction

  function automatic bit legal(input logic [P-1:0] d);
    int r = int'(d[31:28]);
    int c = int'(d[27:24]);
    if (r == 15 && c == 15) return 1'b1;
    return (r <= ROWS + 1) && (c <= COLUMS + 1);
  endfunction

  // Channel behaviour: flush wins, pop frees room for a same-cycle push, illegal always drops
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        mq[i].delete();
        mdrop[i] = 0;
        mund[i]  = 1'b0;
      end else if (flush[i]) begin
        mq[i].delete();
      end else begin
        int sz = mq[i].size();
        bit pop_ok = popin[i] && (sz > 0);
        bit store = 1'b0;
        logic [P-1:0] d = data_in[i*P +: P];
        if (popin[i] && sz == 0) mund[i] = 1'b1;
        if (push[i]) begin
          if (!legal(d) || (sz == DEPTH && !pop_ok)) begin
            if (mdrop[i] < 65535) mdrop[i]++;
          end else store = 1'b1;
        end
        if (pop_ok) void'(mq[i].pop_front());
        if (store) mq[i].push_back(d);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NCH; i++) begin
      int sz = mq[i].size();
      logic [P-1:0] head = (sz > 0) ? mq[i][0] : '0;
      chk($sformatf("pndng[%0d]", i), 64'(pndng_i_in[i]), 64'(sz > 0));
      chk($sformatf("full[%0d]", i), 64'(full[i]), 64'(sz == DEPTH));
      chk($sformatf("occ[%0d]", i), 64'(occ[i*OW +: OW]), 64'(sz));
      chk($sformatf("data[%0d]", i), 64'(data_out_i_in[i*P +: P]), 64'(head));
      chk($sformatf("drop[%0d]", i), 64'(drop_cnt[i*16 +: 16]), 64'(mdrop[i]));
      chk($sformatf("unf[%0d]", i), 64'(underflow[i]), 64'(mund[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 1'b0;
    push = '0;
    flush = '0;
    popin = '0;
    data_in = '0;
  endtask

  logic [P-1:0] exp37 [33];
  logic [P-1:0] newpkt;
  logic [P-1:0] d;

  initial begin
    idle();
    reset = 1'b1;
    push = '1;
    popin = '1;
    tick();
    tick();
    chk("reset_pndng", 64'(pndng_i_in), 64'(0));
    chk("reset_occ", 64'(occ[63:0]), 64'(0));

    // Single push on ch0 appears one cycle later
    idle();
    push[0] = 1'b1;
    data_in[0 +: P] = 40'h00_12_5A5A5A;
    tick();
    idle();
    chk("d036_pndng", 64'(pndng_i_in[0]), 64'(1));
    chk("d036_data", 64'(data_out_i_in[0 +: P]), 64'h00_125A_5A5A);
    chk("d036_occ", 64'(occ[0 +: OW]), 64'(1));

    // Fill ch3 past depth
    for (int k = 0; k < 33; k++) begin
      exp37[k] = pkt(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 24'($urandom));
      idle();
      push[3] = 1'b1;
      data_in[3*P +: P] = exp37[k];
      tick();
    end
    idle();
    chk("d037_full", 64'(full[3]), 64'(1));
    chk("d037_occ", 64'(occ[3*OW +: OW]), 64'(32));
    chk("d037_drop", 64'(drop_cnt[3*16 +: 16]), 64'(1));
    chk("d037_head", 64'(data_out_i_in[3*P +: P]), 64'(exp37[0]));

    // Push with pop at full
    newpkt = pkt(4'h2, 4'h3, 24'hC0FFEE);
    push[3] = 1'b1;
    popin[3] = 1'b1;
    data_in[3*P +: P] = newpkt;
    tick();
    idle();
    chk("d038_occ", 64'(occ[3*OW +: OW]), 64'(32));
    chk("d038_drop", 64'(drop_cnt[3*16 +: 16]), 64'(1));
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("d037_order%0d", k), 64'(data_out_i_in[3*P +: P]),
          64'((k < 31) ? exp37[k+1] : newpkt));
      popin[3] = 1'b1;
      tick();
    end
    idle();
    chk("d038_empty", 64'(pndng_i_in[3]), 64'(0));

    // Illegal destination drops, broadcast accepted
    push[5] = 1'b1;
    data_in[5*P +: P] = pkt(4'h7, 4'h1, 24'h111111);
    tick();
    chk("d039_drop", 64'(drop_cnt[5*16 +: 16]), 64'(1));
    chk("d039_occ0", 64'(occ[5*OW +: OW]), 64'(0));
    data_in[5*P +: P] = pkt(4'hF, 4'hF, 24'hBCBCBC);
    tick();
    idle();
    chk("d039_bcast", 64'(data_out_i_in[5*P +: P]), 64'h00_FFBC_BCBC);
    chk("d039_drop1", 64'(drop_cnt[5*16 +: 16]), 64'(1));

    // Underflow on ch2 and flush of ch1 with same-cycle push
    popin[2] = 1'b1;
    tick();
    idle();
    tick();
    chk("d040_unf", 64'(underflow[2]), 64'(1));
    for (int k = 0; k < 10; k++) begin
      push[1] = 1'b1;
      data_in[1*P +: P] = pkt(4'h1, 4'h1, 24'(k));
      tick();
    end
    chk("d040_occ10", 64'(occ[1*OW +: OW]), 64'(10));
    flush[1] = 1'b1;
    tick();
    idle();
    chk("d040_flush", 64'(occ[1*OW +: OW]), 64'(0));
    chk("d040_unf_hold", 64'(underflow[2]), 64'(1));

    // Random traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      for (int i = 0; i < NCH; i++) begin
        int sel = int'($urandom_range(0, 99));
        if (sel < 10) d = pkt(4'($urandom_range(6, 14)), 4'($urandom), 24'($urandom));
        else if (sel < 15) d = pkt(4'hF, 4'hF, 24'($urandom));
        else d = pkt(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 24'($urandom));
        data_in[i*P +: P] = d;
        push[i]  = ($urandom_range(0, 99) < 55);
        popin[i] = ($urandom_range(0, 99) < 40);
        flush[i] = ($urandom_range(0, 99) < 3);
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    // Reset in the middle of a burst on all channels
    for (int k = 0; k < 5; k++) begin
      idle();
      push = '1;
      popin = 16'($urandom);
      for (int i = 0; i < NCH; i++)
        data_in[i*P +: P] = pkt(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 24'($urandom));
      tick();
    end
    reset = 1'b1;
    popin = '1;
    flush = '1;
    tick();
    chk("d041_pndng", 64'(pndng_i_in), 64'(0));
    chk("d041_full", 64'(full), 64'(0));
    chk("d041_occ", 64'(occ[63:0] | occ[95:64]), 64'(0));
    chk("d041_drop", 64'(drop_cnt[63:0] | drop_cnt[127:64] | drop_cnt[191:128] | drop_cnt[255:192]), 64'(0));
    chk("d041_unf", 64'(underflow), 64'(0));
    chk("d041_data", 64'(|data_out_i_in), 64'(0));
    idle();
    push[9] = 1'b1;
    data_in[9*P +: P] = pkt(4'h3, 4'h4, 24'hABCDEF);
    tick();
    idle();
    chk("d041_after", 64'(data_out_i_in[9*P +: P]), 64'h00_34AB_CDEF);
    chk("d041_occ1", 64'(occ[9*OW +: OW]), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
